// File: rtl/display_message_ctrl_pkg.sv
// Shared types and default contents for the status message display controller.
package display_message_ctrl_pkg;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   // Default geometry that the default table is laid out for
   localparam int DEF_DIGITS = 4;
   localparam int DEF_CODE_W = 4;

   // Blank digit: all ones at any code width
   localparam logic                  DEF_BLANK_BIT  = 1'b1;
   localparam logic [DEF_CODE_W-1:0] DEF_CODE_BLANK = {DEF_CODE_W{DEF_BLANK_BIT}};

   // Glyph codes understood by the display driver (code F is reserved for blank)
   localparam logic [3:0] G_F = 4'h0;
   localparam logic [3:0] G_U = 4'h1;
   localparam logic [3:0] G_L = 4'h2;
   localparam logic [3:0] G_I = 4'h3;
   localparam logic [3:0] G_B = 4'h4;
   localparam logic [3:0] G_E = 4'h5;
   localparam logic [3:0] G_R = 4'h6;
   localparam logic [3:0] G_A = 4'h7;
   localparam logic [3:0] G_O = 4'h9;
   localparam logic [3:0] G_P = 4'hA;

   // Leftmost digit in the most significant nibble; LIBERADO truncated to 4 digits
   localparam logic [15:0] MSG_FULL     = {G_F, G_U, G_L, G_L};   // 16'h0122
   localparam logic [15:0] MSG_LIBERADO = {G_L, G_I, G_B, G_E};   // 16'h2345
   localparam logic [15:0] MSG_PARE     = {G_P, G_A, G_R, G_E};   // 16'hA765
   localparam logic [15:0] MSG_ERRO     = {G_E, G_R, G_R, G_O};   // 16'h5669

   // Message i sits at slice [i*16 +: 16]
   localparam logic [4*16-1:0] DEFAULT_MSG_TABLE = {MSG_ERRO, MSG_PARE, MSG_LIBERADO, MSG_FULL};

endpackage

// File: rtl/display_message_ctrl_prio.sv
// Generic priority encoder: reports the highest set request index.
module prio_encoder_n #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     i_req,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   // Scan upward so the highest set bit wins
   always_comb begin
      o_idx = '0;
      o_any = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (i_req[i]) begin
            o_idx = IDX_W'(i);
            o_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/display_message_ctrl.sv
// Status message display controller: picks the highest-priority request,
// shows its table entry, holds it after the request drops, optional blink.
module display_message_ctrl
   import display_message_ctrl_pkg::*;
#(
   parameter int                                N_MSG      = 4,
   parameter int                                DIGITS     = DEF_DIGITS,
   parameter int                                CODE_W     = DEF_CODE_W,
   parameter int                                HOLD_CYC   = 50_000_000,
   parameter int                                BLINK_CYC  = 25_000_000,
   parameter logic [N_MSG-1:0]                  BLINK_MASK = {N_MSG{1'b0}},
   parameter logic [N_MSG*DIGITS*CODE_W-1:0]    MSG_TABLE  = (N_MSG*DIGITS*CODE_W)'(DEFAULT_MSG_TABLE),
   parameter logic [CODE_W-1:0]                 CODE_BLANK = {CODE_W{DEF_BLANK_BIT}}
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_MSG-1:0]           msg_req,
   output logic [DIGITS*CODE_W-1:0]   disp_word,
   output logic [$clog2(N_MSG)-1:0]   msg_id,
   output logic                       msg_valid
);

   localparam int ID_W    = $clog2(N_MSG);
   localparam int MSG_W   = DIGITS * CODE_W;
   localparam int CNT_MAX = (HOLD_CYC > BLINK_CYC) ? HOLD_CYC : BLINK_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYC - 1);
   localparam logic [MSG_W-1:0] BLANK_WORD = {DIGITS{CODE_BLANK}};

   state_e            r_state;
   logic [ID_W-1:0]   r_id;
   logic [CNT_W-1:0]  r_hold_cnt;
   logic [CNT_W-1:0]  r_blink_cnt;
   logic              r_phase;
   logic [MSG_W-1:0]  r_disp;
   logic              r_valid;

   logic [ID_W-1:0]   w_win;
   logic              w_any;
   logic              w_preempt;
   logic [31:0]       w_base;
   logic [MSG_W-1:0]  w_msg_word;
   logic              w_blanked;

   prio_encoder_n #(
      .N     (N_MSG),
      .IDX_W (ID_W)
   ) u_prio (
      .i_req (msg_req),
      .o_idx (w_win),
      .o_any (w_any)
   );

   // Only a strictly higher index may take over the display
   assign w_preempt  = w_any && (w_win > r_id);

   // Table lookup is a plain indexed part-select on the current id
   assign w_base     = 32'(r_id) * 32'(MSG_W);
   assign w_msg_word = MSG_TABLE[w_base +: MSG_W];
   assign w_blanked  = BLINK_MASK[r_id] && r_phase;

   // Controller FSM; outputs are registered from the current state so they
   // trail any state/id change by exactly one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_id        <= '0;
         r_hold_cnt  <= '0;
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
         r_disp      <= BLANK_WORD;
         r_valid     <= 1'b0;
      end else begin
         r_valid <= (r_state != ST_IDLE);
         r_disp  <= ((r_state == ST_IDLE) || w_blanked) ? BLANK_WORD : w_msg_word;

         // Blink timer runs whenever a message is up; entries below restart it
         if (r_state != ST_IDLE) begin
            if (r_blink_cnt >= BLINK_LAST) begin
               r_blink_cnt <= '0;
               r_phase     <= ~r_phase;
            end else begin
               r_blink_cnt <= r_blink_cnt + 1'b1;
            end
         end

         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_state     <= ST_SHOW;
                  r_id        <= w_win;
                  r_blink_cnt <= '0;
                  r_phase     <= 1'b0;
               end
            end
            ST_SHOW: begin
               if (w_preempt) begin
                  r_id        <= w_win;
                  r_blink_cnt <= '0;
                  r_phase     <= 1'b0;
               end else if (!msg_req[r_id]) begin
                  r_state    <= ST_HOLD;
                  r_hold_cnt <= HOLD_LAST;
               end
            end
            ST_HOLD: begin
               if (w_preempt) begin
                  r_state     <= ST_SHOW;
                  r_id        <= w_win;
                  r_hold_cnt  <= '0;
                  r_blink_cnt <= '0;
                  r_phase     <= 1'b0;
               end else if (msg_req[r_id]) begin
                  // Same message comes back: keep blink cadence running
                  r_state    <= ST_SHOW;
                  r_hold_cnt <= '0;
               end else if (r_hold_cnt == '0) begin
                  if (w_any) begin
                     r_state     <= ST_SHOW;
                     r_id        <= w_win;
                     r_blink_cnt <= '0;
                     r_phase     <= 1'b0;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_hold_cnt <= r_hold_cnt - 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign disp_word = r_disp;
   assign msg_id    = r_id;
   assign msg_valid = r_valid;

endmodule

// File: tb/tb_display_message_ctrl.sv
// Directed bench for display_message_ctrl with short hold/blink timing.
module tb_display_message_ctrl;

   localparam logic [15:0] T0 = 16'h0122;   // FULL
   localparam logic [15:0] T1 = 16'h2345;   // LIBERADO
   localparam logic [15:0] T2 = 16'hA765;   // PARE
   localparam logic [15:0] T3 = 16'h5669;   // ERRO
   localparam logic [15:0] BL = 16'hFFFF;

   logic        clk;
   logic        rst_n;
   logic [3:0]  msg_req;
   logic [15:0] disp_word;
   logic [1:0]  msg_id;
   logic        msg_valid;

   int n_checks = 0;
   int n_fail   = 0;

   display_message_ctrl #(
      .N_MSG      (4),
      .DIGITS     (4),
      .CODE_W     (4),
      .HOLD_CYC   (8),
      .BLINK_CYC  (4),
      .BLINK_MASK (4'b1000)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .msg_req   (msg_req),
      .disp_word (disp_word),
      .msg_id    (msg_id),
      .msg_valid (msg_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      msg_req = 4'b0000;
      tick(3);
      n_checks++;
      if (disp_word !== BL) begin
         n_fail++; $display("FAIL reset_disp got %h exp %h", disp_word, BL);
      end
      n_checks++;
      if (msg_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid got %b exp 0", msg_valid);
      end
      n_checks++;
      if (msg_id !== 2'd0) begin
         n_fail++; $display("FAIL reset_id got %0d exp 0", msg_id);
      end
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_show_basic();
      msg_req = 4'b0001;
      tick();
      n_checks++;
      if (msg_valid !== 1'b0 || disp_word !== BL) begin
         n_fail++; $display("FAIL show_latency1 got v=%b %h exp v=0 %h", msg_valid, disp_word, BL);
      end
      tick();
      n_checks++;
      if (disp_word !== T0 || msg_id !== 2'd0 || msg_valid !== 1'b1) begin
         n_fail++; $display("FAIL show_t0 got %h id=%0d v=%b exp %h id=0 v=1", disp_word, msg_id, msg_valid, T0);
      end
   endtask

   task automatic test_hold();
      int cnt;
      msg_req = 4'b0000;
      tick();
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (msg_valid !== 1'b1) break;
         cnt++;
      end
      n_checks++;
      if (cnt != 8) begin
         n_fail++; $display("FAIL hold_len got %0d exp 8", cnt);
      end
      n_checks++;
      if (disp_word !== BL || msg_valid !== 1'b0) begin
         n_fail++; $display("FAIL hold_end got %h v=%b exp %h v=0", disp_word, msg_valid, BL);
      end
   endtask

   task automatic test_preempt();
      msg_req = 4'b0010;
      tick(2);
      n_checks++;
      if (msg_id !== 2'd1 || disp_word !== T1) begin
         n_fail++; $display("FAIL pre_show1 got id=%0d %h exp id=1 %h", msg_id, disp_word, T1);
      end
      msg_req = 4'b0101;
      tick();
      n_checks++;
      if (msg_id !== 2'd2) begin
         n_fail++; $display("FAIL pre_up got id=%0d exp 2", msg_id);
      end
      tick();
      n_checks++;
      if (disp_word !== T2) begin
         n_fail++; $display("FAIL pre_up_disp got %h exp %h", disp_word, T2);
      end
      msg_req = 4'b0000;
      tick(12);
      n_checks++;
      if (msg_valid !== 1'b0) begin
         n_fail++; $display("FAIL pre_idle1 got v=%b exp 0", msg_valid);
      end
      // lower request must not displace id 1
      msg_req = 4'b0010;
      tick(2);
      msg_req = 4'b0011;
      tick(3);
      n_checks++;
      if (msg_id !== 2'd1 || disp_word !== T1) begin
         n_fail++; $display("FAIL pre_low got id=%0d %h exp id=1 %h", msg_id, disp_word, T1);
      end
      // drop id 1, id 0 waits for the full hold
      msg_req = 4'b0001;
      tick(8);
      n_checks++;
      if (msg_id !== 2'd1 || msg_valid !== 1'b1) begin
         n_fail++; $display("FAIL pre_wait got id=%0d v=%b exp id=1 v=1", msg_id, msg_valid);
      end
      tick();
      n_checks++;
      if (msg_id !== 2'd0) begin
         n_fail++; $display("FAIL pre_after_hold got id=%0d exp 0", msg_id);
      end
      tick();
      n_checks++;
      if (disp_word !== T0 || msg_valid !== 1'b1) begin
         n_fail++; $display("FAIL pre_after_disp got %h v=%b exp %h v=1", disp_word, msg_valid, T0);
      end
      msg_req = 4'b0000;
      tick(12);
   endtask

   task automatic test_blink();
      logic [15:0] exp_w;
      int bad;
      msg_req = 4'b1000;
      tick();
      bad = 0;
      for (int k = 0; k < 16; k++) begin
         tick();
         exp_w = (((k / 4) % 2) == 0) ? T3 : BL;
         n_checks++;
         if (disp_word !== exp_w || msg_valid !== 1'b1) begin
            n_fail++; bad++;
            $display("FAIL blink_%0d got %h v=%b exp %h v=1", k, disp_word, msg_valid, exp_w);
         end
      end
      tick(3);
      msg_req = 4'b0000;
      tick(14);
      n_checks++;
      if (msg_valid !== 1'b0 || disp_word !== BL) begin
         n_fail++; $display("FAIL blink_idle got %h v=%b exp %h v=0", disp_word, msg_valid, BL);
      end
   endtask

   task automatic test_reset_hold();
      msg_req = 4'b0010;
      tick(2);
      msg_req = 4'b0000;
      tick(3);
      n_checks++;
      if (msg_valid !== 1'b1) begin
         n_fail++; $display("FAIL rh_inhold got v=%b exp 1", msg_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (disp_word !== BL || msg_valid !== 1'b0 || msg_id !== 2'd0) begin
         n_fail++; $display("FAIL rh_async got %h v=%b id=%0d exp %h v=0 id=0", disp_word, msg_valid, msg_id, BL);
      end
      msg_req = 4'b0010;
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (msg_id !== 2'd1) begin
         n_fail++; $display("FAIL rh_reserve got id=%0d exp 1", msg_id);
      end
      tick();
      n_checks++;
      if (disp_word !== T1 || msg_valid !== 1'b1) begin
         n_fail++; $display("FAIL rh_disp got %h v=%b exp %h v=1", disp_word, msg_valid, T1);
      end
      msg_req = 4'b0000;
      tick(12);
   endtask

   task automatic test_reassert_hold();
      msg_req = 4'b0001;
      tick(2);
      msg_req = 4'b0000;
      tick(5);                    // hold counter now at 3
      msg_req = 4'b0001;
      for (int k = 0; k < 15; k++) begin
         tick();
         n_checks++;
         if (disp_word !== T0 || msg_valid !== 1'b1 || msg_id !== 2'd0) begin
            n_fail++; $display("FAIL reassert_%0d got %h v=%b id=%0d exp %h v=1 id=0", k, disp_word, msg_valid, msg_id, T0);
         end
      end
      msg_req = 4'b0000;
      tick(12);
      n_checks++;
      if (msg_valid !== 1'b0) begin
         n_fail++; $display("FAIL reassert_idle got v=%b exp 0", msg_valid);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      msg_req = 4'b0000;
      test_reset();
      test_show_basic();
      test_hold();
      test_preempt();
      test_blink();
      test_reset_hold();
      test_reassert_hold();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/display_message_ctrl.md
DISPLAY_MESSAGE_CTRL -- requirements
Module: display_message_ctrl

Interface
REQ-001 SHALL have parameter N_MSG, default 4, number of status message channels (2..16).
REQ-002 SHALL have parameter DIGITS, default 4, number of display digits per message word.
REQ-003 SHALL have parameter CODE_W, default 4, code width per digit.
REQ-004 SHALL have parameter HOLD_CYC, default 50_000_000, minimum display cycles after request drop (>=1).
REQ-005 SHALL have parameter BLINK_CYC, default 25_000_000, cycles per blink half-period (>=1).
REQ-006 SHALL have parameter BLINK_MASK, default {N_MSG{1'b0}}, where bit i=1 makes message i blink.
REQ-007 SHALL have parameter MSG_TABLE, width N_MSG*DIGITS*CODE_W, where message i occupies slice [i*DIGITS*CODE_W +: DIGITS*CODE_W].
REQ-008 SHALL have parameter CODE_BLANK, default all-ones CODE_W, the per-digit blank code.
REQ-009 SHALL have port clk, input, 1, the single system clock.
REQ-010 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port msg_req, input, N_MSG, level requests; bit N_MSG-1 has highest priority.
REQ-012 SHALL have port disp_word, output, DIGITS*CODE_W, registered display word.
REQ-013 SHALL have port msg_id, output, clog2(N_MSG), index of the displayed message.
REQ-014 SHALL have port msg_valid, output, 1, high while any message is displayed.

Function
REQ-015 SHALL compute winner = the highest set index of msg_req, combinationally, using a priority encoder.
REQ-016 SHALL use FSM states IDLE, SHOW, HOLD.
REQ-017 IDLE: on any msg_req bit set, SHALL go to SHOW the next cycle, latching msg_id=winner and clearing the blink counter and phase.
REQ-018 SHOW: while msg_req[msg_id]=1, SHALL stay in SHOW; when it drops, SHALL go to HOLD and load hold counter=HOLD_CYC-1.
REQ-019 HOLD: SHALL decrement the hold counter each cycle and go to IDLE on a cycle when the counter equals 0 and msg_req=0.
REQ-020 HOLD with msg_req!=0 on expiry SHALL go directly to SHOW with the new winner instead of IDLE.
REQ-021 Preemption: in SHOW or HOLD, a winner index above msg_id SHALL replace msg_id next cycle, enter SHOW, and restart blink.
REQ-022 A lower-priority request SHALL never preempt; it is served only after the current message completes HOLD.
REQ-023 A re-asserted msg_req[msg_id] during HOLD SHALL return to SHOW with the same msg_id, and the blink counter SHALL NOT be reset.
REQ-024 disp_word SHALL be registered (1-cycle latency from state/id change), equal to the MSG_TABLE slice of msg_id in SHOW/HOLD, and all digits CODE_BLANK in IDLE.
REQ-025 If BLINK_MASK[msg_id]=1, the phase SHALL toggle every BLINK_CYC cycles, phase=1 SHALL output all CODE_BLANK, and the first phase after entry SHALL be 0 (visible).
REQ-026 msg_valid SHALL be 1 in SHOW/HOLD and 0 in IDLE, registered and aligned with disp_word.
REQ-027 All counters SHALL be sized clog2(max(HOLD_CYC,BLINK_CYC)+1) and SHALL never wrap past 0.

Reset
REQ-028 rst_n=0 SHALL force asynchronously: state=IDLE, msg_id=0, msg_valid=0, disp_word=all CODE_BLANK, counters=0, phase=0.
REQ-029 Reset asserted mid-SHOW/HOLD SHALL abandon the message; after release, a still-high request SHALL be re-served from IDLE.

Structure
REQ-030 A shared package SHALL hold the state enum, CODE_BLANK default, and the default 4-message table (FULL, LIBERADO, PARE, ERRO digit codes).
REQ-031 The priority encoder SHALL be a sub-module prio_encoder_n (parameter N, outputs index and any).
REQ-032 The table lookup SHALL be an indexed part-select; no per-message hardcoded mux.

Verification (bench: N_MSG=4, HOLD_CYC=8, BLINK_CYC=4, BLINK_MASK=4'b1000)
REQ-033 Reset -> disp_word=16'hFFFF, msg_valid=0; assert msg_req=4'b0001 -> 2 cycles later disp_word=table[0], msg_id=0.
REQ-034 msg_req[0] 1->0 -> display held exactly 8 cycles, then all-blank and msg_valid=0.
REQ-035 In SHOW id 1, set msg_req=4'b0101 -> msg_id=2 next cycle; set 4'b0011 while showing id 1 -> msg_id stays 1.
REQ-036 msg_req=4'b1000 held 20 cycles -> table[3] visible 4 cycles, blank 4, visible 4, blank 4, repeating.
REQ-037 rst_n pulsed low during HOLD -> outputs blank immediately (async); after release with msg_req=4'b0010 -> msg_id=1 shown again.
REQ-038 During HOLD of id 0 at count 3, assert msg_req=4'b0001 -> returns to SHOW id 0 with no blank gap.
